// File: rtl/sp_link_master.sv
// Host-side master for the accelerator shift port: serializes 64-bit words into
// the data/weight SIPOs and deserializes PISO reads. Optional macro: SP_PARITY_EN.
//
// Ports: clk, reset (sync, active high); wr_valid/wr_ready/wr_data/wr_sel write
// handshake; rd_req, rd_valid/rd_data/rd_err read result; busy;
// pins sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load, ps_out.
module sp_link_master #(
  parameter int W           = 64,
  parameter int CAPTURE_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  input  logic         wr_sel,
  input  logic         rd_req,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         rd_err,
  output logic         busy,
  output logic         sipo_en,
  output logic         sipo_en2,
  output logic         sp_din,
  output logic         sp_load,
  output logic         sp_load2,
  output logic         ps_load,
  input  logic         ps_out
);

`ifdef SP_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int CMAX  = (NB > CAPTURE_LAT) ? NB : CAPTURE_LAT;
  localparam int CW    = $clog2(CMAX) + 1;
  localparam int WLAST = (CAPTURE_LAT > 1) ? CAPTURE_LAT - 2 : 0;

  typedef enum logic [2:0] {
    IDLE, SHIFT, COMMIT, RD_LOAD, RD_WAIT, RD_SHIFT, RD_DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           sel_q;
  logic [NB-2:0]  tx_sh;
  logic [NB-2:0]  rx_sh;
  logic [NB-1:0]  tx_frame;
  logic [NB-1:0]  rx_next;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Frame on the wire: word bits LSB first, then the parity bit if enabled.
`ifdef SP_PARITY_EN
  assign tx_frame = {^wr_data, wr_data};
`else
  assign tx_frame = wr_data;
`endif

  assign rx_next = {ps_out, rx_sh};

`ifdef SP_PARITY_EN
  logic err_q;
  assign rd_err = err_q;
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_q    <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sipo_en  <= 1'b0;
      sipo_en2 <= 1'b0;
      sp_din   <= 1'b0;
      sp_load  <= 1'b0;
      sp_load2 <= 1'b0;
      ps_load  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef SP_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_valid) begin
            // Bit 0 goes out with the first enable; the rest queue in tx_sh.
            sel_q    <= wr_sel;
            sp_din   <= tx_frame[0];
            tx_sh    <= tx_frame[NB-1:1];
            sipo_en  <= ~wr_sel;
            sipo_en2 <= wr_sel;
            cnt      <= '0;
            state    <= SHIFT;
          end else if (rd_req) begin
            ps_load <= 1'b1;
            cnt     <= '0;
            state   <= RD_LOAD;
          end
        end
        SHIFT: begin
          if (cnt == CW'(NB - 1)) begin
            sipo_en  <= 1'b0;
            sipo_en2 <= 1'b0;
            sp_din   <= 1'b0;
            sp_load  <= ~sel_q;
            sp_load2 <= sel_q;
            state    <= COMMIT;
          end else begin
            cnt    <= cnt + 1'b1;
            sp_din <= tx_sh[0];
            tx_sh  <= tx_sh >> 1;
          end
        end
        COMMIT: begin
          sp_load  <= 1'b0;
          sp_load2 <= 1'b0;
          state    <= IDLE;
        end
        RD_LOAD: begin
          ps_load <= 1'b0;
          cnt     <= '0;
          state   <= (CAPTURE_LAT == 1) ? RD_SHIFT : RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == CW'(WLAST)) begin
            cnt   <= '0;
            state <= RD_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_SHIFT: begin
          rx_sh <= rx_next[NB-1:1];
          if (cnt == CW'(NB - 1)) begin
            rd_data  <= rx_next[W-1:0];
            rd_valid <= 1'b1;
`ifdef SP_PARITY_EN
            // Even parity: data XOR parity bit must be zero.
            err_q    <= ^rx_next;
`endif
            state    <= RD_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_link_master.sv
// Self-checking bench for sp_link_master with SIPO/PISO pin models.
// Works with or without SP_PARITY_EN defined.
module tb_sp_link_master;

  localparam int W   = 64;
  localparam int LAT = 1;
`ifdef SP_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [W-1:0]  wr_data = '0;
  logic          wr_sel = 1'b0;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_err;
  logic          busy;
  logic          sipo_en, sipo_en2, sp_din;
  logic          sp_load, sp_load2, ps_load;
  logic          ps_out = 1'b0;

  int errors = 0;
  int checks = 0;
  int ovl    = 0;
  int n_ld   = 0;

  logic [NB-1:0] sr1 = '0, sr2 = '0, cap1 = '0, cap2 = '0;
  logic [NB-1:0] piso_word = '0;
  logic [NB-1:0] psr = '0;

  always #5 clk = ~clk;

  sp_link_master #(.W(W), .CAPTURE_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_sel(wr_sel),
    .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .busy(busy),
    .sipo_en(sipo_en), .sipo_en2(sipo_en2), .sp_din(sp_din),
    .sp_load(sp_load), .sp_load2(sp_load2),
    .ps_load(ps_load), .ps_out(ps_out)
  );

  // SIPO models: shift LSB first, commit on load strobe.
  always @(posedge clk) begin
    if (sipo_en)  sr1 <= {sp_din, sr1[NB-1:1]};
    if (sipo_en2) sr2 <= {sp_din, sr2[NB-1:1]};
    if (sp_load)  cap1 <= sr1;
    if (sp_load2) cap2 <= sr2;
  end

  // PISO model: first bit valid the cycle after ps_load.
  always @(posedge clk) begin
    if (ps_load) begin
      ps_out <= piso_word[0];
      psr    <= piso_word >> 1;
    end else begin
      ps_out <= psr[0];
      psr    <= psr >> 1;
    end
  end

  always @(negedge clk) begin
    if ($countones({sipo_en, sipo_en2, sp_load, sp_load2, ps_load}) > 1)
      ovl++;
    if (sp_load | sp_load2) n_ld++;
  end

  function automatic logic [NB-1:0] frame_of(input logic [W-1:0] w);
`ifdef SP_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic do_write(input logic [W-1:0] d, input logic sel);
    logic [NB-1:0] fr;
    logic [6:0] exp_v, got_v;
    logic [NB-1:0] cap;
    fr = frame_of(d);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_sel = sel;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data = {$urandom, $urandom};
    wr_sel = ~sel;
    for (int i = 1; i <= NB + 1; i++) begin
      @(negedge clk);
      if (i <= NB)
        exp_v = {1'b0, ~sel, sel, fr[i-1], 3'b000};
      else
        exp_v = {1'b0, 3'b000, ~sel, sel, 1'b0};
      got_v = {wr_ready, sipo_en, sipo_en2, sp_din,
               sp_load, sp_load2, ps_load};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL write_cyc%0d pins=%b exp=%b", i, got_v, exp_v);
      end
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_ready rdy=%b busy=%b exp 1/0", wr_ready, busy);
    end
    cap = sel ? cap2 : cap1;
    checks++;
    if (cap !== fr) begin
      errors++;
      $display("FAIL write_commit got=%h exp=%h", cap, fr);
    end
  endtask

  task automatic do_read(input logic [NB-1:0] fr, input logic exp_err);
    int t, t_ps, t_v, n_ps;
    logic [W-1:0] got_d;
    logic got_e;
    piso_word = fr;
    @(negedge clk);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    t = 0; t_ps = -1; t_v = -1; n_ps = 0;
    got_d = '0; got_e = 1'b0;
    while (t_v < 0 && t < NB + 40) begin
      @(negedge clk);
      t++;
      if (ps_load) begin
        n_ps++;
        if (t_ps < 0) t_ps = t;
      end
      if (rd_valid) begin
        t_v = t; got_d = rd_data; got_e = rd_err;
      end
    end
    checks++;
    if (t_ps != 1 || n_ps != 1) begin
      errors++;
      $display("FAIL read_psload at=%0d n=%0d exp 1/1", t_ps, n_ps);
    end
    checks++;
    if (t_v != 1 + LAT + NB) begin
      errors++;
      $display("FAIL read_latency got=%0d exp=%0d", t_v, 1 + LAT + NB);
    end
    checks++;
    if (got_d !== fr[W-1:0]) begin
      errors++;
      $display("FAIL read_data got=%h exp=%h", got_d, fr[W-1:0]);
    end
    checks++;
    if (got_e !== exp_err) begin
      errors++;
      $display("FAIL read_err got=%b exp=%b", got_e, exp_err);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_pulse vld=%b rdy=%b exp 0/1", rd_valid, wr_ready);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fsm rdy=%b busy=%b exp 1/0", wr_ready, busy);
    end
    checks++;
    if ({sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pins got=%b exp=000000",
               {sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load});
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd vld=%b data=%h err=%b exp 0/0/0",
               rd_valid, rd_data, rd_err);
    end
  endtask

  task automatic test_write_basic;
    do_write(64'h0000_0000_0000_0001, 1'b0);
    do_write(64'hA5A5_0F0F_DEAD_BEEF, 1'b1);
  endtask

  task automatic test_read_basic;
    do_read(frame_of(64'h0123_4567_89AB_CDEF), 1'b0);
  endtask

  task automatic test_random;
    logic [W-1:0] w;
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      do_write(w, 1'($urandom_range(0, 1)));
      w = {$urandom, $urandom};
      do_read(frame_of(w), 1'b0);
    end
  endtask

  task automatic test_rd_hold;
    logic [W-1:0] w;
    w = {$urandom, $urandom};
    do_read(frame_of(w), 1'b0);
    do_write({$urandom, $urandom}, 1'b0);
    checks++;
    if (rd_data !== w) begin
      errors++;
      $display("FAIL rd_hold got=%h exp=%h", rd_data, w);
    end
  endtask

  task automatic test_collision;
    logic [W-1:0] d, r;
    logic sel;
    int t, t_ld, t_ps, t_v;
    logic [W-1:0] got_d;
    d = {$urandom, $urandom};
    r = {$urandom, $urandom};
    sel = 1'($urandom_range(0, 1));
    piso_word = frame_of(r);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_sel = sel; rd_req = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    t = 0; t_ld = -1; t_ps = -1; t_v = -1; got_d = '0;
    while (t_v < 0 && t < 3 * NB + 40) begin
      @(negedge clk);
      t++;
      if ((sp_load | sp_load2) && t_ld < 0) t_ld = t;
      if (ps_load && t_ps < 0) begin
        t_ps = t;
        rd_req = 1'b0;
      end
      if (rd_valid) begin
        t_v = t; got_d = rd_data;
      end
    end
    rd_req = 1'b0;
    checks++;
    if (t_ld != NB + 1 || t_ps != NB + 3) begin
      errors++;
      $display("FAIL collide_order load=%0d psload=%0d exp %0d/%0d",
               t_ld, t_ps, NB + 1, NB + 3);
    end
    checks++;
    if ((sel ? cap2 : cap1) !== frame_of(d)) begin
      errors++;
      $display("FAIL collide_wr got=%h exp=%h", sel ? cap2 : cap1, frame_of(d));
    end
    checks++;
    if (t_v != NB + 3 + LAT + NB || got_d !== r) begin
      errors++;
      $display("FAIL collide_rd at=%0d data=%h exp %0d/%h",
               t_v, got_d, NB + 3 + LAT + NB, r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    int n0;
    n0 = n_ld;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = {$urandom, $urandom};
    wr_sel = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_pins got=%b exp=000000",
               {sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load});
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready rdy=%b busy=%b exp 1/0", wr_ready, busy);
    end
    repeat (NB) @(negedge clk);
    checks++;
    if (n_ld != n0) begin
      errors++;
      $display("FAIL midrst_noload loads=%0d exp=%0d", n_ld, n0);
    end
    do_write(64'hFFFF_FFFF_FFFF_FFFF, 1'($urandom_range(0, 1)));
  endtask

`ifdef SP_PARITY_EN
  task automatic test_parity;
    do_write(64'h3, 1'b0);
    checks++;
    if (cap1[W] !== 1'b0) begin
      errors++;
      $display("FAIL parity_tx got=%b exp=0", cap1[W]);
    end
    do_read({1'b0, 64'h1}, 1'b1);
    do_read({1'b1, 64'h1}, 1'b0);
  endtask
`endif

  task automatic test_overlap;
    checks++;
    if (ovl != 0) begin
      errors++;
      $display("FAIL strobe_overlap cycles=%0d exp=0", ovl);
    end
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_read_basic;
    test_random;
    test_rd_hold;
    test_collision;
    test_reset_mid_write;
`ifdef SP_PARITY_EN
    test_parity;
`endif
    test_overlap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sp_link_master.md
Name: sp_link_master

Overview:
- Host-side master for the accelerator's serial shift port.
- Write path: takes 64-bit words on a valid/ready handshake and serializes them LSB-first into the data or weight SIPO using enable, data and load strobes.
- Read path: issues a parallel-load strobe to the PISO, then deserializes the returned bit stream into a 64-bit word.
- Sits between a test/host controller and the sipo_en/sp_din/sp_load/ps_load/ps_out pins.

Parameters:
- W, 64, shift word width in bits (≥2).
- CAPTURE_LAT, 1, cycles from the ps_load cycle to the first valid ps_out bit (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  master can accept a write.
- wr_data  in  W  word to shift out.
- wr_sel  in  1  target: 0 = data SIPO, 1 = weight SIPO.
- rd_req  in  1  request one PISO read.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  W  last captured word.
- rd_err  out  1  parity error on last read (SP_PARITY_EN only, else 0).
- busy  out  1  FSM not IDLE.
- sipo_en  out  1  shift enable, data SIPO.
- sipo_en2  out  1  shift enable, weight SIPO.
- sp_din  out  1  serial bit to both SIPOs.
- sp_load  out  1  commit strobe, data SIPO.
- sp_load2  out  1  commit strobe, weight SIPO.
- ps_load  out  1  PISO parallel-load strobe.
- ps_out  in  1  PISO serial bit.

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (reset). All outputs are registered except wr_ready and busy, which decode state.
- Reset values: all strobes 0, sp_din 0, rd_valid 0, rd_data 0, rd_err 0, FSM IDLE. In IDLE, wr_ready = 1 and busy = 0.
- FSM states: IDLE, SHIFT, COMMIT, RD_LOAD, RD_WAIT, RD_SHIFT, RD_DONE.
- IDLE:
  - wr_valid is accepted in the cycle wr_ready = 1. Latch wr_data and wr_sel, go to SHIFT, clear the bit counter.
  - If wr_valid and rd_req are both high, the write wins. rd_req must be held until the read is accepted; it is not queued.
- SHIFT:
  - Lasts W cycles. Cycle k drives sp_din = word[k] with the selected enable (sipo_en or sipo_en2) = 1. The other enable stays 0.
  - Counter wraps W-1 → COMMIT.
- COMMIT:
  - One cycle. Selected load strobe = 1, enables = 0, sp_din = 0. Then IDLE.
  - Write occupancy is W+2 cycles from accept to wr_ready high again (66 at default).
- rd_req accepted in IDLE with no wr_valid: go to RD_LOAD.
- RD_LOAD:
  - One cycle, ps_load = 1.
  - Then RD_WAIT for CAPTURE_LAT-1 cycles (skipped when CAPTURE_LAT = 1).
- RD_SHIFT:
  - W cycles. Sample ps_out into shift register position k, LSB first.
- RD_DONE:
  - One cycle. rd_data updates, rd_valid = 1. Then IDLE.
  - rd_data holds until the next completed read.
- No PISO or SIPO strobes overlap. Exactly one of {sipo_en, sipo_en2, sp_load, sp_load2, ps_load} is high in any cycle, or none.
- wr_data and wr_sel changing after acceptance have no effect.
- Reset mid-operation: return to IDLE next cycle with all strobes 0.
  - A partially shifted word is never committed; no load pulse is issued.
  - A partially captured read is discarded; no rd_valid, rd_data keeps its prior value.

Optional Feature:
- SP_PARITY_EN defined:
  - SHIFT lasts W+1 cycles. The final bit is even parity over the word (XOR of all W bits), so write occupancy becomes W+3.
  - RD_SHIFT samples W+1 bits. The extra bit is checked.
  - rd_err is set with rd_valid when parity mismatches, cleared on the next good read or on reset.
- SP_PARITY_EN undefined:
  - Exact W-cycle shifts as described above.
  - rd_err is tied to 0.

Test Plan:
- Reset then wr_valid with wr_data = 64'h0000_0000_0000_0001, wr_sel = 0 → sipo_en high 64 cycles, sp_din = 1 only in the first shift cycle, one sp_load pulse at cycle 65, wr_ready back high at cycle 66. sipo_en2 and sp_load2 stay 0 throughout.
- wr_data = 64'hA5A5_0F0F_DEAD_BEEF, wr_sel = 1 → SIPO model captures 64'hA5A5_0F0F_DEAD_BEEF via sp_load2. sipo_en stays 0.
- rd_req with a PISO model loaded with 64'h0123_4567_89AB_CDEF, CAPTURE_LAT = 1 → single ps_load, rd_valid pulse at ps_load + 65, rd_data = 64'h0123_4567_89AB_CDEF.
- wr_valid and rd_req asserted together, both held → write completes first (66 cycles), then the read runs. Strobes never overlap.
- reset asserted at shift cycle 30 of a write → no sp_load/sp_load2 pulse, wr_ready = 1 the cycle after reset deasserts, next write of 64'hFFFF_FFFF_FFFF_FFFF is committed intact.
- With SP_PARITY_EN: write 64'h3 → 65th shifted bit is 0. PISO model returns 64'h1 with parity bit 0 → rd_err = 1. Next read returning 64'h1 with parity bit 1 → rd_err = 0.
